// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 buffered demultiplexer and its channel slots.
package demux_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int N_CH       = 4;
    localparam int SEL_W      = 2;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One-entry channel buffer: loads a routed word, drains to its consumer, otherwise holds.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   CH_EMPTY | no word held; out_valid=0, out_data keeps last word
//   CH_FULL  | word held; out_valid=1 until the consumer takes it
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    ch_state_e state_q;
    ch_state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load while full only happens when the consumer drains the same cycle,
    // so load always wins and the slot stays full without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_EMPTY: begin
                if (load) begin
                    state_d = CH_FULL;
                end
            end
            CH_FULL: begin
                if (load) begin
                    state_d = CH_FULL;
                end else if (out_ready) begin
                    state_d = CH_EMPTY;
                end
            end
            default: state_d = CH_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= load_data;
        end
    end

    assign out_valid = (state_q == CH_FULL);

endmodule : demux_slot

// File: rtl/demux1_4_buf.sv
// 1-to-4 demultiplexer with a one-word buffer per channel and an accepted-word counter.
module demux1_4_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [CNT_W-1:0]  xfer_count
);

    logic              accept;
    logic [N_CH-1:0]   load;
    logic [DATA_W-1:0] slot_data [N_CH];
    logic [CNT_W-1:0]  xfer_q;

    // Targeted slot can take a word if empty or draining this cycle.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        assign load[k] = accept && (in_sel == SEL_W'(k));

        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (slot_data[k])
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_q <= '0;
        end else if (accept) begin
            xfer_q <= xfer_q + CNT_W'(1);
        end
    end

    assign xfer_count = xfer_q;

endmodule : demux1_4_buf

// File: tb/tb_demux1_4_buf.sv
// Directed self-checking bench for demux1_4_buf.
module tb_demux1_4_buf;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] xfer_count;
    logic [3:0] od [4];

    int tests_run;
    int tests_failed;

    demux1_4_buf #(.DATA_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        od[0] = out_data0;
        od[1] = out_data1;
        od[2] = out_data2;
        od[3] = out_data3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd1; in_data = 4'hF; out_ready = 4'h0;
        #3;
        tests_run++;
        if (out_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_out_valid got %b want 0000", out_valid);
        end
        tests_run++;
        if (xfer_count !== 8'd0) begin
            tests_failed++; $display("FAIL reset_count got %0d want 0", xfer_count);
        end
        tests_run++;
        if ({out_data0, out_data1, out_data2, out_data3} !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_data got %h want 0000",
                                     {out_data0, out_data1, out_data2, out_data3});
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        step();
        step();
        tests_run++;
        if (xfer_count !== 8'd0 || out_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_no_xfer got cnt=%0d ov=%b want 0/0000",
                                     xfer_count, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in_data = 4'hA; in_sel = 2'd2; in_valid = 1'b1; out_ready = 4'h0;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 4'b0100 || out_data2 !== 4'hA || xfer_count !== 8'd1) begin
            tests_failed++; $display("FAIL single got ov=%b d2=%h cnt=%0d want 0100/a/1",
                                     out_valid, out_data2, xfer_count);
        end
    endtask

    task automatic test_stall();
        in_data = 4'h5; in_sel = 2'd2; in_valid = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL stall_ready got %b want 0", in_ready);
        end
        step();
        tests_run++;
        if (out_data2 !== 4'hA || out_valid !== 4'b0100 || xfer_count !== 8'd1) begin
            tests_failed++; $display("FAIL stall_hold got d2=%h ov=%b cnt=%0d want a/0100/1",
                                     out_data2, out_valid, xfer_count);
        end
        in_sel = 2'd0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL stall_other_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 4'b0101 || out_data0 !== 4'h5 || xfer_count !== 8'd2) begin
            tests_failed++; $display("FAIL stall_other got ov=%b d0=%h cnt=%0d want 0101/5/2",
                                     out_valid, out_data0, xfer_count);
        end
    endtask

    task automatic test_pass_through();
        out_ready = 4'b0101;
        step();
        out_ready = 4'b0000;
        tests_run++;
        if (out_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL drain got ov=%b want 0000", out_valid);
        end
        in_data = 4'h3; in_sel = 2'd1; in_valid = 1'b1;
        step();
        in_data = 4'h7; out_ready = 4'b0010;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL pass_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        tests_run++;
        if (out_valid !== 4'b0010 || out_data1 !== 4'h7 || xfer_count !== 8'd4) begin
            tests_failed++; $display("FAIL pass got ov=%b d1=%h cnt=%0d want 0010/7/4",
                                     out_valid, out_data1, xfer_count);
        end
        out_ready = 4'b0010;
        step();
        out_ready = 4'b0000;
        tests_run++;
        if (out_valid !== 4'b0000 || out_data1 !== 4'h7) begin
            tests_failed++; $display("FAIL empty_hold got ov=%b d1=%h want 0000/7",
                                     out_valid, out_data1);
        end
    endtask

    task automatic test_idle();
        in_data = 4'h9; in_sel = 2'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_sel  = 2'($urandom_range(0, 3));
            in_data = 4'($urandom_range(0, 15));
            step();
        end
        tests_run++;
        if (out_valid !== 4'b1000 || xfer_count !== 8'd5 || out_data3 !== 4'h9) begin
            tests_failed++; $display("FAIL idle got ov=%b cnt=%0d d3=%h want 1000/5/9",
                                     out_valid, xfer_count, out_data3);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] d;
        int         k;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        out_ready = 4'hF;
        for (int i = 0; i < 256; i++) begin
            k = i % 4;
            d = 4'((i * 7 + 3) % 16);
            in_data = d; in_sel = 2'(k); in_valid = 1'b1;
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++; $display("FAIL rr_ready i=%0d got %b want 1", i, in_ready);
            end
            step();
            tests_run++;
            if (od[k] !== d) begin
                tests_failed++; $display("FAIL rr_data i=%0d ch=%0d got %h want %h", i, k, od[k], d);
            end
            tests_run++;
            if (out_valid !== (4'b0001 << k)) begin
                tests_failed++; $display("FAIL rr_valid i=%0d got %b want %b", i, out_valid,
                                         4'b0001 << k);
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (xfer_count !== 8'd0) begin
            tests_failed++; $display("FAIL rr_wrap got %0d want 0", xfer_count);
        end
        step();
        out_ready = 4'h0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            in_data = 4'(i + 1); in_sel = 2'(i); in_valid = 1'b1;
            step();
        end
        tests_run++;
        if (out_valid !== 4'b1111 || xfer_count !== 8'd4 || out_data3 !== 4'h4) begin
            tests_failed++; $display("FAIL fill got ov=%b cnt=%0d d3=%h want 1111/4/4",
                                     out_valid, xfer_count, out_data3);
        end
        in_sel = 2'd0; in_data = 4'hC;
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 4'b0000 || xfer_count !== 8'd0 ||
            {out_data0, out_data1, out_data2, out_data3} !== 16'h0000) begin
            tests_failed++; $display("FAIL async_reset got ov=%b cnt=%0d d=%h want 0000/0/0000",
                                     out_valid, xfer_count,
                                     {out_data0, out_data1, out_data2, out_data3});
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_mid_ready got %b want 1", in_ready);
        end
        step();
        tests_run++;
        if (xfer_count !== 8'd0 || out_valid !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_mid_hold got cnt=%0d ov=%b want 0/0000",
                                     xfer_count, out_valid);
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        in_data = 4'hB; in_sel = 2'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 4'b0010 || out_data1 !== 4'hB || xfer_count !== 8'd1) begin
            tests_failed++; $display("FAIL first_after_reset got ov=%b d1=%h cnt=%0d want 0010/b/1",
                                     out_valid, out_data1, xfer_count);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_stall();
        test_pass_through();
        test_idle();
        test_round_robin();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_demux1_4_buf

// File: doc/demux1_4_buf.md
DEMUX1_4_BUF -- requirements
Module: demux1_4_buf

Interface
REQ-001 Parameter: DATA_W, 4, data width of the input and of each output channel.
REQ-002 Parameter: CNT_W, 8, width of the accepted-transfer counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_data  input  DATA_W  word to be routed.
REQ-006 Port: in_sel  input  2  destination channel index, 0..3.
REQ-007 Port: in_valid  input  1  producer offers in_data/in_sel this cycle.
REQ-008 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-009 Port: out_data0..out_data3  output  DATA_W each  per-channel held word.
REQ-010 Port: out_valid  output  4  bit k high means channel k holds a word.
REQ-011 Port: out_ready  input  4  bit k high means consumer k takes its word this cycle.
REQ-012 Port: xfer_count  output  CNT_W  number of accepted input words, modulo 2^CNT_W.

Function
REQ-013 Each channel SHALL contain a one-entry buffer with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-014 An input transfer SHALL occur in a cycle where in_valid && in_ready.
REQ-015 in_ready SHALL be combinational: !out_valid[in_sel] || out_ready[in_sel].
REQ-016 Output transfer on channel k SHALL occur in a cycle where out_valid[k] && out_ready[k].
REQ-017 Channel k EMPTY->FULL on an input transfer with in_sel==k; out_data_k SHALL load in_data at that edge.
REQ-018 Channel k FULL->EMPTY on an output transfer with no input transfer targeting k in the same cycle.
REQ-019 Simultaneous output transfer on k and input transfer targeting k: channel stays FULL, out_data_k SHALL load the new in_data; no data loss, no bubble.
REQ-020 Channel k FULL, out_ready[k]=0, in_sel==k: in_ready=0, input stalls; words for other channels are not affected by the stall.
REQ-021 Latency SHALL be one cycle: a word accepted at edge N is visible on out_data_k with out_valid[k]=1 after edge N.
REQ-022 Channels not targeted SHALL hold data and state unchanged, except for their own output transfers.
REQ-023 out_data_k SHALL hold its last value while EMPTY; consumers ignore it.
REQ-024 xfer_count SHALL increment by 1 on each input transfer and wrap from 2^CNT_W-1 to 0.
REQ-025 in_valid=0 SHALL cause no state change, whatever the value of in_sel or in_data.
REQ-026 Input transfers SHALL NOT depend on in_valid staying high after acceptance; each accepted cycle is one word.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for clk, clear out_valid to 4'b0000, every out_data_k to 0, and xfer_count to 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; no output transfer is reported after reset assertion.
REQ-029 While rst_n is low, in_ready SHALL be 1, but no transfer is recorded.
REQ-030 The first transfer after reset SHALL be accepted at the first rising clk edge with rst_n high.

Structure
REQ-031 Shared package demux_pkg SHALL hold DATA_W default, N_CH=4, SEL_W=2, and a channel-state enum {CH_EMPTY, CH_FULL}.
REQ-032 One sub-module, demux_slot, SHALL implement a single channel buffer (load, drain, hold) and be instantiated four times.
REQ-033 Top level SHALL contain only select decode, the in_ready mux, and the transfer counter.

Verification
REQ-034 Reset, then in_data=4'hA, in_sel=2, in_valid=1 for one cycle, out_ready=0 -> out_valid=4'b0100, out_data2=4'hA, xfer_count=1.
REQ-035 Channel 2 FULL, out_ready=0, offer 4'h5 to sel=2 -> in_ready=0, out_data2 stays 4'hA; offer 4'h5 to sel=0 -> accepted, out_valid=4'b0101.
REQ-036 Channel 1 FULL with 4'h3, out_ready[1]=1 and input 4'h7 to sel=1 in the same cycle -> in_ready=1, out_valid[1] stays 1, out_data1=4'h7, xfer_count +1.
REQ-037 Send 256 words round-robin over sel 0..3 with all out_ready=1 -> no stall, each channel delivers its words in order, xfer_count returns to 0.
REQ-038 Fill all four channels, then drop rst_n between clock edges -> out_valid=0, xfer_count=0, outputs 0 before the next edge.
REQ-039 in_valid=0 while in_sel and in_data toggle randomly for 20 cycles -> out_valid and xfer_count unchanged.
